mem_controller: RTL

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mic_pkg.sv | 20 ++
 rtl/byte_ram.sv | 45 ++++
 rtl/mem_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared constants, mem_control bit indices and FSM state type
package mic_pkg;

    // Default datapath widths shared with the register bank
    localparam int NBITS_DEF = 32;
    localparam int WORD_DEF  = 8;
    localparam int MEM_DEF   = 3;

    // mem_control bit positions
    localparam int MC_FETCH = 0;
    localparam int MC_RD    = 1;
    localparam int MC_WR    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mc_state_t;

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - single-port synchronous byte RAM, write enable, registered read
module byte_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WORD       = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD-1:0]       wdata,
    output logic [WORD-1:0]       rdata
);

    logic [WORD-1:0] mem [2**DEPTH_LOG2];
    logic [WORD-1:0] rdata_q;
    logic [WORD-1:0] rdata_d;

    // Read register only reloads on an explicit read so it holds the last read byte
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Read data register; cleared by reset, storage array is not
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - wait-state byte memory controller; optional MEM_RANGE_CHECK_EN
module mem_controller
    import mic_pkg::*;
#(
    parameter int NBITS       = NBITS_DEF,
    parameter int WORD        = WORD_DEF,
    parameter int MEM         = MEM_DEF,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MEM-1:0]   mem_control,
    input  logic [NBITS-1:0] mem_addr,
    input  logic [WORD-1:0]  mem_out,
    input  logic             write_enb,
    output logic [WORD-1:0]  mem_in,
    output logic             mem_valid,
    output logic             mem_done,
    output logic             busy,
    output logic             mem_err
);

    mc_state_t             state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [WORD-1:0]       wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  oob_q, oob_d;

    logic                  req_any;
    logic                  oob_in;
    logic                  commit;
    logic                  commit_wr;
    logic                  commit_oob;
    logic                  ram_we;
    logic                  ram_re;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [WORD-1:0]       ram_wdata;
    logic [WORD-1:0]       ram_rdata;

    assign req_any = write_enb | (|mem_control);

`ifdef MEM_RANGE_CHECK_EN
    logic rd_zero_q, rd_zero_d;

    assign oob_in = |mem_addr[NBITS-1:DEPTH_LOG2];

    // An out-of-range read reports zero until the next in-range read completes
    always_comb begin
        rd_zero_d = rd_zero_q;
        if (commit && !commit_wr) begin
            rd_zero_d = commit_oob;
        end
    end

    // Zero-read flag register
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_zero_q <= 1'b0;
        end else begin
            rd_zero_q <= rd_zero_d;
        end
    end

    assign mem_in  = rd_zero_q ? '0 : ram_rdata;
    assign mem_err = (state_q == ST_DONE) && oob_q;
`else
    logic unused_addr_hi;

    // Upper address bits alias onto the storage when range checking is off
    assign unused_addr_hi = ^mem_addr[NBITS-1:DEPTH_LOG2];
    assign oob_in         = 1'b0;
    assign mem_in         = ram_rdata;
    assign mem_err        = 1'b0;
`endif

    // Next-state logic; the storage access is committed on the edge entering DONE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        oob_d      = oob_q;
        commit     = 1'b0;
        commit_wr  = wr_q;
        commit_oob = oob_q;
        ram_addr   = addr_q;
        ram_wdata  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    addr_d  = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d = mem_out;
                    wr_d    = write_enb;
                    oob_d   = oob_in;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        // Zero wait states: the accepting edge is also the commit edge
                        state_d    = ST_DONE;
                        commit     = 1'b1;
                        commit_wr  = write_enb;
                        commit_oob = oob_in;
                        ram_addr   = mem_addr[DEPTH_LOG2-1:0];
                        ram_wdata  = mem_out;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Reset on the commit edge discards the access without touching storage
        ram_we = commit && commit_wr && !commit_oob && reset;
        ram_re = commit && !commit_wr && !commit_oob && reset;
    end

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            oob_q   <= oob_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_done  = (state_q == ST_DONE);
    assign mem_valid = (state_q == ST_DONE) && !wr_q;

    byte_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WORD       (WORD)
    ) u_ram (
        .clk    (clk),
        .resetn (reset),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

endmodule
